// File: rtl/cache_mem_arbiter_if.sv
// Caches-to-memory bus bundle: icache port, dcache port and the single shared RAM port.
`default_nettype none

interface cache_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  // Caches plus RAM side.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter: icache/dcache arbitration onto one RAM port with burst
// lock, data priority and bounded icache starvation.   Revision 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                CLK,
  input  logic                nRST,
  cache_mem_arbiter_if.slave  bus
);

  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [1:0]       RAM_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve, starve_nxt;
  logic             memerr_reg;

  logic d_req, i_starved, access, granted;

  assign d_req     = bus.dREN | bus.dWEN;
  assign i_starved = bus.iREN && (starve >= LIMIT);
  assign access    = (bus.ramstate == RAM_ACCESS);
  assign granted   = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve     <= '0;
      memerr_reg <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve     <= starve_nxt;
      if (granted && bus.ramstate == RAM_ERROR)
        memerr_reg <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    case (state)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_nxt = DGRANT;
        end else if (bus.iREN) begin
          state_nxt  = IGRANT;
          starve_nxt = '0;
        end
      end
      DGRANT: begin
        // Only data words completed while the icache waits count toward starvation.
        if (access && bus.iREN && starve < LIMIT)
          starve_nxt = starve + 1'b1;
        if (!d_req)
          state_nxt = IDLE;
      end
      IGRANT: begin
        if (!bus.iREN)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    case (state)
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dwait    = ~access;
      end
      IGRANT: begin
        bus.ramREN   = 1'b1;
        bus.ramaddr  = bus.iaddr;
        bus.iwait    = ~access;
      end
      default: ;
    endcase
  end

  assign bus.iload  = bus.ramload;
  assign bus.dload  = bus.ramload;
  assign bus.memerr = memerr_reg;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: cycle-level ownership model plus directed scenarios with literal expectations.
`default_nettype none

module tb_cache_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic CLK;
  logic nRST;
  int   checks   = 0;
  int   failures = 0;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  // Model: who owns the RAM (0 nobody, 1 icache, 2 dcache), words the icache has waited through, error seen.
  int owner;
  int starve;
  bit err;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner  <= 0;
      starve <= 0;
      err    <= 1'b0;
    end else begin
      if (owner != 0 && bus.ramstate == ERR) err <= 1'b1;
      if (owner == 0) begin
        if ((bus.dREN || bus.dWEN) && !(bus.iREN && starve >= LIMIT)) owner <= 2;
        else if (bus.iREN) begin
          owner  <= 1;
          starve <= 0;
        end
      end else if (owner == 2) begin
        if (bus.ramstate == ACC && bus.iREN) starve <= (starve + 1 > LIMIT) ? LIMIT : starve + 1;
        if (!(bus.dREN || bus.dWEN)) owner <= 0;
      end else begin
        if (!bus.iREN) owner <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = 0; e_store = 0;
    if (owner == 2) begin
      e_addr  = bus.daddr;
      e_store = bus.dstore;
      e_wen   = bus.dWEN;
      e_ren   = bus.dREN && !bus.dWEN;
      e_dw    = (bus.ramstate != ACC);
    end else if (owner == 1) begin
      e_ren   = 1;
      e_addr  = bus.iaddr;
      e_iw    = (bus.ramstate != ACC);
    end
    check("m_ramREN",   {31'b0, bus.ramREN}, {31'b0, e_ren});
    check("m_ramWEN",   {31'b0, bus.ramWEN}, {31'b0, e_wen});
    check("m_ramaddr",  bus.ramaddr,  e_addr);
    check("m_ramstore", bus.ramstore, e_store);
    check("m_iwait",    {31'b0, bus.iwait},  {31'b0, e_iw});
    check("m_dwait",    {31'b0, bus.dwait},  {31'b0, e_dw});
    check("m_iload",    bus.iload,    bus.ramload);
    check("m_dload",    bus.dload,    bus.ramload);
    check("m_memerr",   {31'b0, bus.memerr}, {31'b0, err});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [1:0]  rs [6];
    logic [31:0] ia [6];
    int          low_cnt;
    rs = '{BUSY, BUSY, ACC, BUSY, BUSY, ACC};
    ia = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h104, 32'h104};

    nRST = 0;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'h0BAD_F00D; bus.ramstate = FREE;
    #12;
    check("rst_iwait",  {31'b0, bus.iwait},  32'd1);
    check("rst_dwait",  {31'b0, bus.dwait},  32'd1);
    check("rst_ramREN", {31'b0, bus.ramREN}, 32'd0);
    check("rst_memerr", {31'b0, bus.memerr}, 32'd0);
    @(negedge CLK); #1 nRST = 1;

    // ERROR during a data grant
    tick();
    bus.dREN = 1; bus.daddr = 32'h10; bus.ramstate = ERR;
    tick();
    #1 check("err_dwait0", {31'b0, bus.dwait}, 32'd1);
    check("err_memerr0", {31'b0, bus.memerr}, 32'd0);
    tick();
    #1 check("err_dwait1", {31'b0, bus.dwait}, 32'd1);
    check("err_memerr1", {31'b0, bus.memerr}, 32'd1);
    bus.ramstate = ACC;
    #1 check("err_dwait_acc", {31'b0, bus.dwait}, 32'd0);
    bus.dREN = 0;
    tick();
    tick();
    #1 check("err_sticky", {31'b0, bus.memerr}, 32'd1);

    // Reset in the middle of a data write
    bus.ramstate = BUSY; bus.dWEN = 1; bus.daddr = 32'h40; bus.dstore = 32'h1234_5678;
    tick();
    #1 check("rw_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
    check("rw_ramaddr", bus.ramaddr, 32'h40);
    #1 nRST = 0;
    #1 check("rw_rst_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
    check("rw_rst_ramaddr", bus.ramaddr, 32'd0);
    check("rw_rst_iwait", {31'b0, bus.iwait}, 32'd1);
    check("rw_rst_dwait", {31'b0, bus.dwait}, 32'd1);
    check("rw_rst_memerr", {31'b0, bus.memerr}, 32'd0);
    bus.dWEN = 0; bus.dREN = 1; bus.daddr = 32'h44;
    @(negedge CLK); #1 nRST = 1;
    tick();
    #1 check("rw_regrant_ren", {31'b0, bus.ramREN}, 32'd1);
    check("rw_regrant_addr", bus.ramaddr, 32'h44);
    bus.dREN = 0;
    tick();

    // Simultaneous requests: dcache first, icache after one bubble
    bus.ramstate = ACC; bus.iREN = 1; bus.iaddr = 32'h200; bus.dREN = 1; bus.daddr = 32'h300;
    tick();
    #1 check("sim_addr_d", bus.ramaddr, 32'h300);
    check("sim_dwait", {31'b0, bus.dwait}, 32'd0);
    check("sim_iwait", {31'b0, bus.iwait}, 32'd1);
    #1 bus.dREN = 0;
    tick();
    #1 check("sim_bubble_ren", {31'b0, bus.ramREN}, 32'd0);
    check("sim_bubble_iwait", {31'b0, bus.iwait}, 32'd1);
    tick();
    #1 check("sim_addr_i", bus.ramaddr, 32'h200);
    check("sim_iwait_i", {31'b0, bus.iwait}, 32'd0);
    bus.iREN = 0;
    tick();

    // dREN and dWEN together: write wins
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEAD_BEEF;
    tick();
    #1 check("rw_both_wen", {31'b0, bus.ramWEN}, 32'd1);
    check("rw_both_ren", {31'b0, bus.ramREN}, 32'd0);
    check("rw_both_store", bus.ramstore, 32'hDEAD_BEEF);
    check("rw_both_addr", bus.ramaddr, 32'h80);
    bus.dREN = 0; bus.dWEN = 0;
    tick();

    // Two-word icache burst with two BUSY cycles per word
    bus.iREN = 1; bus.iaddr = 32'h100; bus.ramstate = BUSY;
    tick();
    low_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      bus.ramstate = rs[k]; bus.iaddr = ia[k]; bus.ramload = 32'hA000_0000 + k;
      #1 check("ib_addr", bus.ramaddr, ia[k]);
      check("ib_iwait", {31'b0, bus.iwait}, (k == 2 || k == 5) ? 32'd0 : 32'd1);
      check("ib_iload", bus.iload, 32'hA000_0000 + k);
      if (!bus.iwait) low_cnt++;
      if (k == 5) bus.iREN = 0;
      tick();
    end
    check("ib_low_cycles", low_cnt, 32'd2);

    // Starvation: icache wins after four completed data words
    bus.ramstate = ACC; bus.iREN = 1; bus.iaddr = 32'h500; bus.dREN = 1;
    for (int b = 0; b < 2; b++) begin
      bus.daddr = 32'h600 + 8 * b;
      tick();
      #1 check("st_d_word0", bus.ramaddr, 32'h600 + 8 * b);
      check("st_iwait", {31'b0, bus.iwait}, 32'd1);
      bus.daddr = 32'h604 + 8 * b;
      tick();
      #1 check("st_d_word1", bus.ramaddr, 32'h604 + 8 * b);
      bus.dREN = 0;
      tick();
      #1 check("st_bubble", {31'b0, bus.ramREN}, 32'd0);
      bus.dREN = 1; bus.daddr = 32'h700;
    end
    tick();
    #1 check("st_igrant_addr", bus.ramaddr, 32'h500);
    check("st_igrant_iwait", {31'b0, bus.iwait}, 32'd0);
    check("st_igrant_dwait", {31'b0, bus.dwait}, 32'd1);
    bus.iREN = 0;
    tick();
    bus.iREN = 1;
    tick();
    #1 check("st_cleared_addr", bus.ramaddr, 32'h700);
    check("st_cleared_dwait", {31'b0, bus.dwait}, 32'd0);
    bus.dREN = 0; bus.iREN = 0;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the instruction cache and data cache for the single shared RAM port on the caches-to-memory boundary. Each cache issues one-word accesses; the arbiter grants one requester at a time, holds the grant for the requester's whole burst, and routes RAM status back as per-cache wait signals. Data accesses have priority, and a bounded-starvation counter guarantees instruction fetch progress.

## Interface

Parameters:
- STARVE_LIMIT, 4: completed data words, with iREN pending, after which the next arbitration goes to the icache.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low for exactly the cycle its word completes.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; low for exactly the cycle its word completes.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  sticky; set on any ERROR cycle during a grant.

## Operation

- States: IDLE, IGRANT, DGRANT.
- IDLE: RAM outputs deasserted. Priority:
  - (dREN|dWEN) and not (iREN and starve ≥ STARVE_LIMIT) → DGRANT.
  - Otherwise iREN → IGRANT.
  - Otherwise stay in IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0. dWEN wins when dREN and dWEN are both high.
  - Else ramREN=dREN.
  - Return to IDLE when dREN|dWEN is low at a clock edge.
- IGRANT: ramREN=1, ramaddr=iaddr, ramstore=0. Return to IDLE when iREN is low at a clock edge.
- Burst lock: the grant is never preempted while the granted requester keeps its request high, including across address changes.
- Wait and data routing:
  - Granted cache: wait = (ramstate != ACCESS).
  - Non-granted cache, or any cache in IDLE: wait = 1.
  - iload and dload both pass ramload through unconditionally.
- Starvation counter:
  - Increments by 1 each DGRANT cycle where ramstate==ACCESS and iREN==1.
  - Saturates at STARVE_LIMIT.
  - Cleared on entry to IGRANT.
- ERROR: the granted cache's wait stays 1 and memerr sets. The grant holds until the requester drops.
- Reset (any time, including mid-burst):
  - State → IDLE, starve=0, memerr=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - iwait=dwait=1.

## Timing

- Arbitration costs one cycle. A request seen in IDLE at edge N is driven to RAM during cycle N+1.
- Word completion is in the same cycle ramstate==ACCESS; wait is combinational from ramstate.
- Releasing a grant costs one IDLE bubble cycle before the next grant. Back-to-back bursts by the same cache also pass through IDLE.
- All state, starve and memerr are registered. RAM outputs, waits and loads are combinational from state and inputs.
- Simultaneous first requests: dcache wins unless the starvation condition holds.
- A request deasserting in the same cycle as its ACCESS completes normally, then goes to IDLE.

## Test plan

- Reset mid-DGRANT write (dWEN=1, daddr=0x40):
  - Required: next cycle ramWEN=0, iwait=dwait=1, memerr=0.
  - Required: after release, a fresh dREN is granted within 1 cycle.
- Simultaneous iREN and dREN from IDLE, RAM ACCESS every cycle:
  - Cycle 1: ramaddr=daddr, dwait=0, iwait=1.
  - dREN drops → 1 IDLE cycle → IGRANT with ramaddr=iaddr.
- dREN and dWEN both high, daddr=0x80, dstore=0xDEADBEEF:
  - Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- Starvation, STARVE_LIMIT=4: iREN held high while the dcache issues repeated 2-word bursts.
  - Required: after 4 completed data words, the next IDLE grants IGRANT even though dREN is high.
  - Required: starve is 0 after the IGRANT entry.
- Two-word icache burst (0x100, then 0x104) with ramstate BUSY,BUSY,ACCESS per word:
  - Required: grant held throughout; iwait low only on the 2 ACCESS cycles; iload = ramload on those cycles.
- ramstate=ERROR during DGRANT:
  - Required: memerr=1 from the next cycle and stays 1 after the burst ends.
  - Required: dwait=1 throughout the ERROR cycles.
